dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache. Sits between the MEM stage and
//  off-chip data memory, and supplies the load data the MEM/WB register latches.

---
 rtl/dcache_ctrl_if.sv | 29 ++
 rtl/dcache_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// Bus bundle for dcache_ctrl: MEM-stage access port plus the line-wide memory port.
// slave = the cache's view, master = the pipeline/memory environment's view.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional DCACHE_STATS_EN adds hit/miss/write-back counters.
module dcache_ctrl #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 5,
  parameter int ADDR_W   = 32
) (
  input  logic        clock_i,
  input  logic        rst_n_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
`endif
);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = 8 << OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;

  state_e              state_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]    miss_tag_q;
  logic [INDEX_W-1:0]  miss_idx_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-3:0] word_sel;
  logic [LINE_W-1:0]   cur_line;
  logic                hit, idle, idle_hit, idle_miss, store_hit;
  logic                unused_addr_lsb;

  assign req_tag         = bus.addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx         = bus.addr_i[OFFSET_W +: INDEX_W];
  assign word_sel        = bus.addr_i[OFFSET_W-1:2];
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign cur_line  = data_q[req_idx];
  assign hit       = bus.req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign idle      = (state_q == IDLE);
  assign idle_hit  = idle & hit;
  assign idle_miss = idle & bus.req_i & ~hit;
  assign store_hit = idle_hit & bus.we_i;

  // Gating with rst_n_i lets stall drop the instant reset asserts, even with req_i held.
  assign bus.stall_o     = rst_n_i & (~idle | idle_miss);
  assign bus.rdata_o     = idle_hit ? cur_line[{word_sel, 5'd0} +: 32] : 32'd0;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (store_hit) dirty_q[req_idx] <= 1'b1;
          if (idle_miss) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            mem_req_q  <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx], req_idx, {OFFSET_W{1'b0}}};
              mem_wdata_q <= data_q[req_idx];
            end else begin
              state_q    <= ALLOCATE;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state_q    <= ALLOCATE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            state_q             <= REFILL;
            mem_req_q           <= 1'b0;
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge clock_i) begin
    if (state_q == ALLOCATE && bus.mem_ack_i) begin
      data_q[miss_idx_q] <= bus.mem_rdata_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_hit) begin
      data_q[req_idx][{word_sel, 5'd0} +: 32] <= bus.wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // replay_q marks the IDLE cycle right after REFILL, whose hit is not a new access.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q <= (state_q == REFILL);
      if (idle_hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (idle_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITEBACK && bus.mem_ack_i) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif
endmodule
